free_list_ctrl: RTL

//  Circular-FIFO allocator for physical register tags in the R10K rename stage.

---
 rtl/free_list_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - circular free list of physical register tags for the rename stage
// Speculative head feeds dispatch, architectural head tracks retire, tail reclaims T_old tags.
module free_list_ctrl #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    parameter int DEPTH       = PHYS_REG_SZ - ARCH_REG_SZ,
    parameter int TAG_W       = $clog2(PHYS_REG_SZ),
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             retire_en,
    input  logic [TAG_W-1:0] retire_t_old,
    input  logic             flush,
    output logic [CNT_W-1:0] free_count,
    output logic             empty,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] tag_buf [DEPTH];
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] arch_head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] spec_cnt;
    logic             err_q;
    logic             retire_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty      = (spec_cnt == '0);
    assign free_count = spec_cnt;
    assign err        = err_q;
    assign alloc_tag  = tag_buf[spec_head];
    assign alloc_gnt  = alloc_req & ~empty & ~flush & ~reset;

    // A retire is only legal against an outstanding allocation, counting one granted this cycle.
    assign retire_ok = retire_en & ((spec_cnt != CNT_W'(DEPTH)) | alloc_gnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_buf[i] <= TAG_W'(ARCH_REG_SZ + i);
            end
            spec_head <= '0;
            arch_head <= '0;
            tail      <= '0;
            spec_cnt  <= CNT_W'(DEPTH);
            err_q     <= 1'b0;
        end else begin
            if (retire_ok) begin
                tag_buf[tail] <= retire_t_old;
                tail          <= ptr_inc(tail);
                arch_head     <= ptr_inc(arch_head);
            end
            if (retire_en && !retire_ok) begin
                err_q <= 1'b1;
            end
            // Flush rewinds to the committed head, including a retire landing this same edge.
            if (flush) begin
                spec_head <= retire_ok ? ptr_inc(arch_head) : arch_head;
                spec_cnt  <= CNT_W'(DEPTH);
            end else begin
                if (alloc_gnt) begin
                    spec_head <= ptr_inc(spec_head);
                end
                if (alloc_gnt && !retire_ok) begin
                    spec_cnt <= spec_cnt - CNT_W'(1);
                end else if (!alloc_gnt && retire_ok) begin
                    spec_cnt <= spec_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
